ctrl_decode_stage: RTL and testbench

Registered, pipelined successor to the combinational control unit: decodes a MIPS instruction word into the full control bundle and holds it in a stall/flush-capable decode register. It also owns the per-core load-linked/store-conditional reservation (link register with snoop invalidation) and a sticky halt latch. It sits between the IF/ID latch and the ID/EX latch of each core in the multicore datapath, with the link-register ports driven from the MEM stage and the coherence snoop bus.

---
 rtl/cpu_types_pkg.sv | 143 ++++++++++++++
 rtl/llsc_link_reg.sv | 56 +++++
 rtl/ctrl_decode_stage.sv | 93 +++++++++
 tb/tb_ctrl_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the decode stage.
//   word_t          32-bit instruction/data word
//   aluop_t         ALU operation select (encoding 0 is the bubble value)
//   ctrl_bundle_t   packed control bundle, field order matches the ctrl_out port
//   decode_ctrl()   instruction word -> control bundle (undefined -> bubble)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } aluop_t;

  typedef struct packed {
    logic   j;
    logic   jr;
    logic   jal;
    logic   beq;
    logic   bne;
    logic   halt;
    logic   RegDst;
    logic   ALUSrc;
    logic   MemToReg;
    logic   RegWrite;
    aluop_t ALUOp;
    logic   ExtOp;
    logic   ShiftOp;
    logic   lui;
    logic   dR_REQ;
    logic   dW_REQ;
    logic   datomic;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Opcodes
  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] ADDIU = 6'h09;
  localparam logic [5:0] SLTI  = 6'h0A;
  localparam logic [5:0] SLTIU = 6'h0B;
  localparam logic [5:0] ANDI  = 6'h0C;
  localparam logic [5:0] ORI   = 6'h0D;
  localparam logic [5:0] XORI  = 6'h0E;
  localparam logic [5:0] LUI   = 6'h0F;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;
  localparam logic [5:0] LL    = 6'h30;
  localparam logic [5:0] SC    = 6'h38;
  localparam logic [5:0] HALT  = 6'h3F;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Every defined instruction sets at least one control bit, so a result
  // equal to CTRL_BUBBLE identifies an undefined opcode/funct.
  function automatic ctrl_bundle_t decode_ctrl(input word_t instr);
    ctrl_bundle_t c;
    logic [19:0]  unused_fields;
    c             = CTRL_BUBBLE;
    unused_fields = instr[25:6];
    case (instr[31:26])
      RTYPE: begin
        c.RegDst   = 1'b1;
        c.RegWrite = 1'b1;
        case (instr[5:0])
          FN_SLL:          begin c.ShiftOp = 1'b1; c.ALUOp = ALU_SLL; end
          FN_SRL:          begin c.ShiftOp = 1'b1; c.ALUOp = ALU_SRL; end
          FN_JR:           begin c = CTRL_BUBBLE; c.jr = 1'b1; end
          FN_ADD, FN_ADDU: c.ALUOp = ALU_ADD;
          FN_SUB, FN_SUBU: c.ALUOp = ALU_SUB;
          FN_AND:          c.ALUOp = ALU_AND;
          FN_OR:           c.ALUOp = ALU_OR;
          FN_XOR:          c.ALUOp = ALU_XOR;
          FN_NOR:          c.ALUOp = ALU_NOR;
          FN_SLT:          c.ALUOp = ALU_SLT;
          FN_SLTU:         c.ALUOp = ALU_SLTU;
          default:         c = CTRL_BUBBLE;
        endcase
      end
      J:   c.j = 1'b1;
      JAL: begin c.jal = 1'b1; c.RegWrite = 1'b1; end
      BEQ: begin c.beq = 1'b1; c.ExtOp = 1'b1; c.ALUOp = ALU_SUB; end
      BNE: begin c.bne = 1'b1; c.ExtOp = 1'b1; c.ALUOp = ALU_SUB; end
      ADDI, ADDIU: begin
        c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ExtOp = 1'b1; c.ALUOp = ALU_ADD;
      end
      SLTI: begin
        c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ExtOp = 1'b1; c.ALUOp = ALU_SLT;
      end
      SLTIU: begin
        c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ExtOp = 1'b1; c.ALUOp = ALU_SLTU;
      end
      ANDI: begin c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ALUOp = ALU_AND; end
      ORI:  begin c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ALUOp = ALU_OR;  end
      XORI: begin c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ALUOp = ALU_XOR; end
      LUI:  begin c.lui = 1'b1; c.ALUSrc = 1'b1; c.RegWrite = 1'b1; end
      LW: begin
        c.dR_REQ = 1'b1; c.MemToReg = 1'b1; c.RegWrite = 1'b1;
        c.ALUSrc = 1'b1; c.ExtOp = 1'b1;
      end
      SW: begin c.dW_REQ = 1'b1; c.ALUSrc = 1'b1; c.ExtOp = 1'b1; end
      // LL/SC address offsets are sign-extended like LW/SW.
      LL: begin
        c.dR_REQ = 1'b1; c.MemToReg = 1'b1; c.RegWrite = 1'b1;
        c.ALUSrc = 1'b1; c.ExtOp = 1'b1; c.datomic = 1'b1;
      end
      SC: begin
        c.dW_REQ = 1'b1; c.RegWrite = 1'b1; c.ALUSrc = 1'b1;
        c.ExtOp = 1'b1; c.datomic = 1'b1;
      end
      HALT:    c.halt = 1'b1;
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// llsc_link_reg: per-core load-linked reservation with snoop invalidation.
//   CLK, RST              clock, synchronous active-high reset
//   ll_set, sc_check      LL retiring / SC evaluating in MEM
//   mem_addr              address of the LL/SC
//   snoop_inv, snoop_addr remote invalidate/write of a line
//   sc_success            combinational SC result
//   link_valid            reservation currently held
module llsc_link_reg #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINK_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ll_set,
  input  logic              sc_check,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_success,
  output logic              link_valid
);

  logic [ADDR_W-1:LINK_LSB] link_addr;
  logic                     link_valid_q;
  logic                     mem_match;
  logic                     snoop_old_hit;
  logic                     snoop_new_hit;
  logic                     unused_low_bits;

  assign unused_low_bits = ^{mem_addr[LINK_LSB-1:0], snoop_addr[LINK_LSB-1:0]};

  assign mem_match     = (mem_addr[ADDR_W-1:LINK_LSB] == link_addr);
  assign snoop_old_hit = snoop_inv && (snoop_addr[ADDR_W-1:LINK_LSB] == link_addr);
  // A snoop landing on the address being linked this cycle kills the new link.
  assign snoop_new_hit = snoop_inv &&
                         (snoop_addr[ADDR_W-1:LINK_LSB] == mem_addr[ADDR_W-1:LINK_LSB]);

  assign sc_success = sc_check && link_valid_q && mem_match;
  assign link_valid = link_valid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid_q <= 1'b0;
      link_addr    <= '0;
    end else if (sc_check) begin
      // SC consumes the reservation; a coincident ll_set is dropped.
      link_valid_q <= 1'b0;
    end else if (ll_set) begin
      link_addr    <= mem_addr[ADDR_W-1:LINK_LSB];
      link_valid_q <= !snoop_new_hit;
    end else if (snoop_old_hit) begin
      link_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered MIPS control decode with stall/flush,
// sticky halt latch and the LL/SC link register.
//   CLK, RST                 clock, synchronous active-high reset
//   imemload, in_valid       instruction from IF/ID and its valid flag
//   stall, flush             hold / bubble the decode register
//   ctrl_out, out_valid      registered control bundle and valid
//   ll_set, sc_check,
//   mem_addr, snoop_inv,
//   snoop_addr               link register inputs from MEM and snoop bus
//   sc_success, link_valid   SC result (combinational), reservation state
//   halted                   sticky halt
module ctrl_decode_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LINK_LSB       = 2,
  parameter int unsigned BUBBLE_ON_HALT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       imemload,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output ctrl_bundle_t      ctrl_out,
  output logic              out_valid,
  input  logic              ll_set,
  input  logic              sc_check,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              sc_success,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              link_valid,
  output logic              halted
);

  ctrl_bundle_t ctrl_q;
  ctrl_bundle_t dec;
  ctrl_bundle_t load_ctrl;
  logic         valid_q;
  logic         load_valid;
  logic         halted_q;

  always_comb begin
    dec        = decode_ctrl(imemload);
    load_ctrl  = CTRL_BUBBLE;
    load_valid = 1'b0;
    if (in_valid && !((BUBBLE_ON_HALT != 0) && halted_q) && (dec != CTRL_BUBBLE)) begin
      load_ctrl  = dec;
      load_valid = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q   <= CTRL_BUBBLE;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (flush) begin
        ctrl_q  <= CTRL_BUBBLE;
        valid_q <= 1'b0;
      end else if (!stall) begin
        ctrl_q  <= load_ctrl;
        valid_q <= load_valid;
      end
      // A halt only commits when it advances out of decode.
      if (ctrl_q.halt && !stall && !flush) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign ctrl_out  = ctrl_q;
  assign out_valid = valid_q;
  assign halted    = halted_q;

  llsc_link_reg #(
    .ADDR_W   (ADDR_W),
    .LINK_LSB (LINK_LSB)
  ) u_link (
    .CLK        (CLK),
    .RST        (RST),
    .ll_set     (ll_set),
    .sc_check   (sc_check),
    .mem_addr   (mem_addr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .sc_success (sc_success),
    .link_valid (link_valid)
  );

endmodule

// File: tb/tb_ctrl_decode_stage.sv
module tb_ctrl_decode_stage;
  import cpu_types_pkg::*;

  logic         CLK;
  logic         RST;
  logic [31:0]  imemload;
  logic         in_valid;
  logic         stall;
  logic         flush;
  ctrl_bundle_t ctrl_out;
  logic         out_valid;
  logic         ll_set;
  logic         sc_check;
  logic [31:0]  mem_addr;
  logic         sc_success;
  logic         snoop_inv;
  logic [31:0]  snoop_addr;
  logic         link_valid;
  logic         halted;

  ctrl_decode_stage #(
    .ADDR_W         (32),
    .LINK_LSB       (2),
    .BUBBLE_ON_HALT (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemload   (imemload),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .ctrl_out   (ctrl_out),
    .out_valid  (out_valid),
    .ll_set     (ll_set),
    .sc_check   (sc_check),
    .mem_addr   (mem_addr),
    .sc_success (sc_success),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .link_valid (link_valid),
    .halted     (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {K_CTRL, K_VALID, K_SC, K_LINK, K_HALTED} kind_e;

  string       q_tag[$];
  kind_e       q_kind[$];
  logic [31:0] q_val[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] cbits(input ctrl_bundle_t c);
    return 32'(c);
  endfunction

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_CTRL:   return cbits(ctrl_out);
      K_VALID:  return 32'(out_valid);
      K_SC:     return 32'(sc_success);
      K_LINK:   return 32'(link_valid);
      default:  return 32'(halted);
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_e k, input logic [31:0] v);
    q_tag.push_back(tag);
    q_kind.push_back(k);
    q_val.push_back(v);
  endtask

  task automatic drain();
    string       tag;
    kind_e       k;
    logic [31:0] exp;
    logic [31:0] obs;
    while (q_tag.size() > 0) begin
      tag = q_tag.pop_front();
      k   = q_kind.pop_front();
      exp = q_val.pop_front();
      obs = observe(k);
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Advance one edge, then compare everything queued for after that edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask

  // Compare combinational outputs within the current cycle.
  task automatic settle();
    #1;
    drain();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] w,
                          input ctrl_bundle_t e, input logic v);
    imemload = w;
    in_valid = 1'b1;
    expect_val(tag, K_CTRL, cbits(e));
    expect_val({tag, "_v"}, K_VALID, 32'(v));
    tick();
  endtask

  ctrl_bundle_t e_addu, e_lw, e_beq, e_j, e_jal, e_jr, e_ori, e_sll, e_lui;
  ctrl_bundle_t e_ll, e_sc, e_halt, e_bub;

  localparam logic [31:0] W_ADDU = 32'h00221821;
  localparam logic [31:0] W_LW   = 32'h8C220004;
  localparam logic [31:0] W_BEQ  = 32'h10220003;
  localparam logic [31:0] W_HALT = 32'hFC000000;

  initial begin
    e_bub  = '0;
    e_addu = '0; e_addu.RegDst = 1; e_addu.RegWrite = 1; e_addu.ALUOp = ALU_ADD;
    e_lw   = '0; e_lw.dR_REQ = 1; e_lw.MemToReg = 1; e_lw.RegWrite = 1;
                 e_lw.ALUSrc = 1; e_lw.ExtOp = 1; e_lw.ALUOp = ALU_ADD;
    e_beq  = '0; e_beq.beq = 1; e_beq.ExtOp = 1; e_beq.ALUOp = ALU_SUB;
    e_j    = '0; e_j.j = 1;
    e_jal  = '0; e_jal.jal = 1; e_jal.RegWrite = 1;
    e_jr   = '0; e_jr.jr = 1;
    e_ori  = '0; e_ori.ALUSrc = 1; e_ori.RegWrite = 1; e_ori.ALUOp = ALU_OR;
    e_sll  = '0; e_sll.RegDst = 1; e_sll.RegWrite = 1; e_sll.ShiftOp = 1;
                 e_sll.ALUOp = ALU_SLL;
    e_lui  = '0; e_lui.lui = 1; e_lui.ALUSrc = 1; e_lui.RegWrite = 1;
    e_ll   = '0; e_ll.dR_REQ = 1; e_ll.MemToReg = 1; e_ll.RegWrite = 1;
                 e_ll.ALUSrc = 1; e_ll.ExtOp = 1; e_ll.datomic = 1;
    e_sc   = '0; e_sc.dW_REQ = 1; e_sc.RegWrite = 1; e_sc.ALUSrc = 1;
                 e_sc.ExtOp = 1; e_sc.datomic = 1;
    e_halt = '0; e_halt.halt = 1;

    RST = 1; imemload = W_ADDU; in_valid = 1; stall = 0; flush = 0;
    ll_set = 0; sc_check = 0; mem_addr = '0; snoop_inv = 0; snoop_addr = '0;

    // Reset state
    expect_val("rst_ctrl", K_CTRL, cbits(e_bub));
    expect_val("rst_valid", K_VALID, 0);
    expect_val("rst_halted", K_HALTED, 0);
    expect_val("rst_link", K_LINK, 0);
    tick();
    RST = 0;

    // Decode, one-cycle latency
    load_chk("addu", W_ADDU, e_addu, 1);
    load_chk("lw", W_LW, e_lw, 1);

    // Stall holds LW for three cycles while BEQ waits on imemload
    imemload = W_BEQ; stall = 1;
    for (int i = 0; i < 3; i++) begin
      expect_val("stall_hold", K_CTRL, cbits(e_lw));
      expect_val("stall_hold_v", K_VALID, 1);
      tick();
    end
    stall = 0;
    load_chk("beq_after_stall", W_BEQ, e_beq, 1);

    // in_valid low and undefined opcode both capture a bubble
    imemload = W_ADDU; in_valid = 0;
    expect_val("inval_ctrl", K_CTRL, cbits(e_bub));
    expect_val("inval_v", K_VALID, 0);
    tick();
    load_chk("undef_op", 32'hF0000000, e_bub, 0);
    load_chk("undef_fn", 32'h00221801, e_bub, 0);

    // Other decode patterns
    load_chk("j", 32'h08000010, e_j, 1);
    load_chk("jal", 32'h0C000010, e_jal, 1);
    load_chk("jr", 32'h03E00008, e_jr, 1);
    load_chk("ori", 32'h34220005, e_ori, 1);
    load_chk("sll", 32'h00021080, e_sll, 1);
    load_chk("lui", 32'h3C010001, e_lui, 1);
    load_chk("ll", 32'hC0220000, e_ll, 1);
    load_chk("sc", 32'hE0220000, e_sc, 1);

    // flush beats stall
    load_chk("pre_flush", W_ADDU, e_addu, 1);
    stall = 1; flush = 1;
    expect_val("flush_ctrl", K_CTRL, cbits(e_bub));
    expect_val("flush_v", K_VALID, 0);
    tick();
    stall = 0; flush = 0; in_valid = 0;

    // LL then SC with low-bit offset succeeds, second SC fails
    ll_set = 1; mem_addr = 32'h100;
    expect_val("ll_sc_idle", K_SC, 0);
    settle();
    expect_val("ll_link", K_LINK, 1);
    tick();
    ll_set = 0; sc_check = 1; mem_addr = 32'h102;
    expect_val("sc_ok", K_SC, 1);
    settle();
    expect_val("sc_clear", K_LINK, 0);
    tick();
    mem_addr = 32'h100;
    expect_val("sc_again", K_SC, 0);
    settle();
    tick();
    sc_check = 0;

    // Snoop miss keeps the link, snoop hit clears it
    ll_set = 1; mem_addr = 32'h200;
    expect_val("ll2_link", K_LINK, 1);
    tick();
    ll_set = 0; snoop_inv = 1; snoop_addr = 32'h204;
    expect_val("snoop_miss", K_LINK, 1);
    tick();
    snoop_addr = 32'h200;
    expect_val("snoop_hit", K_LINK, 0);
    tick();
    snoop_inv = 0; sc_check = 1;
    expect_val("sc_after_snoop", K_SC, 0);
    settle();
    tick();
    sc_check = 0;

    // ll_set with matching snoop: snoop wins
    ll_set = 1; mem_addr = 32'h280; snoop_inv = 1; snoop_addr = 32'h283;
    expect_val("ll_snoop_race", K_LINK, 0);
    tick();
    snoop_inv = 0;

    // ll_set with sc_check: SC against old link, link clears
    mem_addr = 32'h300;
    expect_val("ll3_link", K_LINK, 1);
    tick();
    sc_check = 1; mem_addr = 32'h380;
    expect_val("ll_sc_race_sc", K_SC, 0);
    settle();
    expect_val("ll_sc_race_link", K_LINK, 0);
    tick();
    ll_set = 1; sc_check = 0; mem_addr = 32'h300;
    tick();
    sc_check = 1;
    expect_val("ll_sc_same_sc", K_SC, 1);
    settle();
    expect_val("ll_sc_same_link", K_LINK, 0);
    tick();
    ll_set = 0; sc_check = 0;

    // RST mid-LL discards the reservation
    ll_set = 1; mem_addr = 32'h400;
    expect_val("ll4_link", K_LINK, 1);
    tick();
    ll_set = 0; RST = 1;
    expect_val("rst_link_clr", K_LINK, 0);
    tick();
    RST = 0;

    // Halt held by stall does not latch until it advances
    load_chk("halt_a", W_HALT, e_halt, 1);
    stall = 1;
    expect_val("halt_stalled", K_HALTED, 0);
    tick();
    stall = 0;
    expect_val("halt_released", K_HALTED, 1);
    load_chk("addu_same_edge", W_ADDU, e_addu, 1);
    load_chk("addu_halted", W_ADDU, e_bub, 0);
    RST = 1;
    expect_val("rst_halt_clr", K_HALTED, 0);
    tick();
    RST = 0;

    // Flush on the halt cycle cancels it
    load_chk("halt_b", W_HALT, e_halt, 1);
    flush = 1;
    expect_val("halt_flushed", K_HALTED, 0);
    expect_val("halt_flushed_ctrl", K_CTRL, cbits(e_bub));
    tick();
    flush = 0;
    expect_val("halt_flushed_stays", K_HALTED, 0);
    load_chk("addu_after_cancel", W_ADDU, e_addu, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
